// File: rtl/branch_predictor.sv
// Branch predictor: 2-bit saturating BHT plus a direct-mapped BTB, with combinational lookup.
// Defining BP_GSHARE_EN enables gshare indexing (PC bits XOR global history); otherwise the predictor is bimodal.
module branch_predictor #(
    parameter int BP_IDX_BITS  = 8,
    parameter int BTB_IDX_BITS = 4,
    parameter int DBITS        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DBITS-1:0]       fe_pc,
    output logic                   pred_taken,
    output logic [DBITS-1:0]       pred_target,
    output logic [BP_IDX_BITS-1:0] pred_idx,
    input  logic                   upd_valid,
    input  logic                   upd_taken,
    input  logic [BP_IDX_BITS-1:0] upd_idx,
    input  logic [DBITS-1:0]       upd_target,
    input  logic [DBITS-1:0]       upd_pc
);
    localparam int BHT_N = 1 << BP_IDX_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int TAG_W = DBITS - BTB_IDX_BITS - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [DBITS-1:0] target;
    } btb_entry_t;

    logic [1:0]             bht [BHT_N];
    btb_entry_t             btb [BTB_N];
    logic [BP_IDX_BITS-1:0] ghr;

    logic [BTB_IDX_BITS-1:0] fe_btb_idx, upd_btb_idx;
    logic [TAG_W-1:0]        fe_tag, upd_tag;
    btb_entry_t              fe_entry;
    logic                    btb_hit;

    assign fe_btb_idx  = fe_pc[BTB_IDX_BITS+1:2];
    assign fe_tag      = fe_pc[DBITS-1:BTB_IDX_BITS+2];
    assign upd_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
    assign upd_tag     = upd_pc[DBITS-1:BTB_IDX_BITS+2];

    // Lookup reads registered state only, so a same-cycle update is seen one cycle later.
    assign pred_idx    = fe_pc[BP_IDX_BITS+1:2] ^ ghr;
    assign fe_entry    = btb[fe_btb_idx];
    assign btb_hit     = fe_entry.valid && (fe_entry.tag == fe_tag);
    assign pred_taken  = !reset && bht[pred_idx][1] && btb_hit;
    assign pred_target = pred_taken ? fe_entry.target : fe_pc + DBITS'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht[upd_idx] != 2'b11)
                bht[upd_idx] <= bht[upd_idx] + 2'b01;
            else if (!upd_taken && bht[upd_idx] != 2'b00)
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
        end
    end

    // Only taken branches allocate; a not-taken resolution leaves the BTB alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_N; i++) btb[i] <= '0;
        end else if (upd_valid && upd_taken) begin
            btb[upd_btb_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
        end
    end

`ifdef BP_GSHARE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          ghr <= '0;
        else if (upd_valid) ghr <= {ghr[BP_IDX_BITS-2:0], upd_taken};
    end
`else
    assign ghr = '0;
`endif

    // Byte-offset bits of the PCs carry no information for prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, fe_pc[1:0], upd_pc[1:0]};

endmodule
